// File: rtl/vp_ctrl_pkg.sv
// Shared vector-pipeline control definitions: default sizes, FSM state type and
// the register-address type also used by the decode stage.
package vp_ctrl_pkg;

  localparam int unsigned VP_NREG      = 16;
  localparam int unsigned VP_MAX_BEATS = 8;
  localparam int unsigned VP_AW        = $clog2(VP_NREG);
  localparam int unsigned VP_BW        = $clog2(VP_MAX_BEATS);

  typedef logic [VP_AW-1:0] vreg_addr_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/vreg_scoreboard.sv
// Pending-write scoreboard for the vector register file. The pend output already
// has this cycle's write-back removed so a hazard can resolve in the same cycle.
module vreg_scoreboard
  import vp_ctrl_pkg::*;
#(
  parameter int unsigned NREG = VP_NREG,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  output logic [NREG-1:0] pend
);

  logic [NREG-1:0] sb;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  assign pend = sb & ~clr_mask;

  // Set is applied after the clear, so a same-cycle set of the same register wins.
  always_ff @(posedge clk) begin
    if (rst) sb <= '0;
    else     sb <= pend | set_mask;
  end

endmodule

// File: rtl/id_exe_ctrl.sv
// ID/EXE issue controller: gates loading of ID/EXE on EXE occupancy and register
// hazards, then sequences the multi-beat instruction through EXE.
module id_exe_ctrl
  import vp_ctrl_pkg::*;
#(
  parameter int unsigned NREG      = VP_NREG,
  parameter int unsigned MAX_BEATS = VP_MAX_BEATS,
  localparam int unsigned AW       = $clog2(NREG),
  localparam int unsigned BW       = $clog2(MAX_BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_src1,
  input  logic [AW-1:0] id_src2,
  input  logic          id_use1,
  input  logic          id_use2,
  input  logic [AW-1:0] id_dest,
  input  logic          id_wr,
  input  logic [BW:0]   id_beats,
  input  logic          flush,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_dest,
  output logic          id_exe_load,
  output logic          id_exe_bubble,
  output logic          if_id_stall,
  output logic          exe_valid,
  output logic [BW-1:0] exe_beat,
  output logic          exe_first,
  output logic          exe_last
);

  state_t          state;
  logic [BW-1:0]   beat_cnt;
  logic [BW:0]     beats_q;
  logic [BW:0]     beats_eff;
  logic [NREG-1:0] pend;
  logic            exec;
  logic            last;
  logic            hazard;
  logic            exe_free;
  logic            accept;

  vreg_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept & id_wr),
    .set_addr (id_dest),
    .clr_en   (wb_valid),
    .clr_addr (wb_dest),
    .pend     (pend)
  );

  assign exec      = (state == EXEC);
  assign last      = exec && ({1'b0, beat_cnt} == beats_q - (BW+1)'(1));
  assign hazard    = (id_use1 & pend[id_src1]) | (id_use2 & pend[id_src2]) |
                     (id_wr & pend[id_dest]);
  assign exe_free  = ~exec | last;
  assign accept    = id_valid & ~flush & ~hazard & exe_free & ~rst;
  assign beats_eff = (id_beats == '0) ? (BW+1)'(1) : id_beats;

  // Reset is synchronous, so state may still read EXEC during the rst cycle;
  // the EXE-facing outputs are masked to present an empty stage immediately.
  assign id_exe_load   = accept;
  assign id_exe_bubble = rst | (~accept & exe_free);
  assign if_id_stall   = id_valid & ~flush & ~accept & ~rst;
  assign exe_valid     = exec & ~rst;
  assign exe_beat      = rst ? '0 : beat_cnt;
  assign exe_first     = exec & ~rst & (beat_cnt == '0);
  assign exe_last      = last & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      beats_q  <= '0;
    end else if (accept) begin
      state    <= EXEC;
      beat_cnt <= '0;
      beats_q  <= beats_eff;
    end else if (exec) begin
      if (last) state <= IDLE;
      else      beat_cnt <= beat_cnt + BW'(1);
    end
  end

endmodule

// File: doc/id_exe_ctrl.md
# id_exe_ctrl

Issue and sequencing controller for the vector pipeline's ID/EXE register. Each cycle it decides whether the decoded vector instruction in ID may be loaded into ID/EXE. Loading is held back while the EXE stage is still busy with a multi-beat vector operation, or while a source/destination vector register has a write pending (scoreboard). Once an instruction is loaded, the block sequences its element-group beats through EXE and drives stall and bubble controls to IF/ID and ID/EXE.

## Interface
Parameters:
- NREG, 16: number of vector registers; register address width is log2(NREG) = 4.
- MAX_BEATS, 8: maximum EXE beats per instruction; beat index width BW = log2(MAX_BEATS) = 3.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a decoded instruction.
- id_src1, id_src2  in  4  source vector register addresses.
- id_use1, id_use2  in  1  the corresponding source is read.
- id_dest  in  4  destination vector register.
- id_wr  in  1  the instruction writes id_dest.
- id_beats  in  BW+1  EXE beats required, 1..MAX_BEATS; a value of 0 is treated as 1.
- flush  in  1  kill the instruction in ID this cycle.
- wb_valid  in  1  a vector write-back completes this cycle.
- wb_dest  in  4  register being written back.
- id_exe_load  out  1  ID/EXE captures ID fields at the next posedge.
- id_exe_bubble  out  1  ID/EXE captures a NOP at the next posedge.
- if_id_stall  out  1  IF/ID holds its contents.
- exe_valid  out  1  EXE holds an active beat.
- exe_beat  out  BW  current beat index.
- exe_first, exe_last  out  1  first / last beat of the current instruction.

## Operation
- FSM states: IDLE (EXE empty) and EXEC (beats in progress).
- Registers: beat_cnt, beats_q (latched id_beats, with 0 mapped to 1), scoreboard sb[NREG-1:0].
- pend = sb & ~(wb_valid ? onehot(wb_dest) : 0). Write-back clears are bypassed into the same-cycle hazard check.
- hazard = (id_use1 & pend[id_src1]) | (id_use2 & pend[id_src2]) | (id_wr & pend[id_dest]). The id_dest term covers WAW.
- exe_free = IDLE | (EXEC & exe_last).
- accept = id_valid & ~flush & ~hazard & exe_free & ~rst.
- id_exe_load = accept.
- id_exe_bubble = ~accept & exe_free. When EXEC is not on its last beat, ID/EXE holds, so neither load nor bubble is asserted.
- if_id_stall = id_valid & ~flush & ~accept.
- On accept:
  - beat_cnt <= 0 and beats_q <= id_beats.
  - Next state is EXEC, including the back-to-back case where accept happens on the last beat.
  - If id_wr, set sb[id_dest].
- EXEC, not last beat: beat_cnt increments.
- EXEC, last beat, no accept: next state is IDLE.
- exe_valid = (state == EXEC); exe_beat = beat_cnt.
- exe_first = EXEC & (beat_cnt == 0); exe_last = EXEC & (beat_cnt == beats_q - 1).
- wb_valid clears sb[wb_dest]. If the same register is set by accept in the same cycle, the set wins.
- flush: the ID instruction is not accepted, there is no stall, and a bubble is inserted when exe_free. The in-flight EXE instruction is older and completes normally; the scoreboard is untouched.
- wb_valid on a register whose sb bit is already clear is a no-op.

## Timing
- Reset: state = IDLE; beat_cnt, beats_q and sb are cleared. While rst is high:
  - exe_valid, exe_first, exe_last, id_exe_load and if_id_stall are 0; exe_beat is 0.
  - id_exe_bubble is 1.
- rst asserted mid-operation: the beat sequence is abandoned and all pending scoreboard bits are dropped at that edge.
- accept at edge k makes beat 0 visible in cycle k+1. An N-beat instruction occupies cycles k+1..k+N, and the next instruction can load at edge k+N (zero dead cycles).
- A 1-beat instruction asserts exe_first and exe_last in the same cycle.
- Hazard resolution: a wb_valid for the blocking register in cycle c allows accept in cycle c.
- Control outputs are combinational from registered state plus ID, flush and wb inputs; there is no path from the outputs back to the inputs.

## Structure
- Shared package vp_ctrl_pkg holds:
  - NREG and MAX_BEATS defaults and the derived widths;
  - the state enum {IDLE, EXEC};
  - the register-address typedef, which is shared with the decode stage.
- Sub-module vreg_scoreboard:
  - inputs set_en/set_addr and clr_en/clr_addr;
  - outputs the bypassed pend vector (the pend definition above).
  - The FSM, beat counter and issue logic stay in id_exe_ctrl.

## Test plan
- Back-to-back: A (beats=4, dest 3) then B (beats=1, independent).
  - A loads at edge 0; beats 0..3 run in cycles 1..4.
  - B loads at edge 4 with no stall and shows exe_first = exe_last = 1 in cycle 5.
- RAW stall: A writes v5; B reads v5.
  - B holds if_id_stall = 1 with no load until wb_valid/wb_dest = 5.
  - B is accepted in that same cycle.
- WAW plus simultaneous set/clear:
  - wb clears v7 while a new writer of v7 is accepted in the same cycle; sb[7] ends at 1.
  - A second writer of v7 then stalls.
- Flush during EXEC: a 6-beat op is at beat 2 and flush is asserted with B valid.
  - B is not loaded and if_id_stall = 0.
  - Beats 3..5 still complete, and no bubble is inserted until the last beat.
- Reset mid-op: rst asserted at beat 1 of an 8-beat op with sb[2] set.
  - The next cycle shows exe_valid = 0 and sb = 0.
  - A reader of v2 is accepted on the first cycle after rst deasserts.
- id_beats = 0: treated as a single beat, so exe_first = exe_last = 1.
